// File: rtl/vram_arbiter.sv
// Contended video RAM arbiter: shares the 16K video RAM between the video fetcher and the Z80.
// Derives the CPU clock enables from the pixel enable. While video owns the RAM, it suppresses
// the CPU rising edge so the CPU waits. It also sequences CPU reads and single-strobe writes.
module vram_arbiter #(
    parameter logic [1:0] CONT_PAGE  = 2'b01,
    parameter bit         IO_CONTEND = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ce_i,
    input  logic        cn_i,
    input  logic [12:0] va_i,
    output logic [7:0]  vd_o,
    input  logic        cpu_mreq_n_i,
    input  logic        cpu_iorq_n_i,
    input  logic        cpu_rd_n_i,
    input  logic        cpu_wr_n_i,
    input  logic [15:0] cpu_a_i,
    input  logic [7:0]  cpu_do_i,
    output logic [7:0]  cpu_di_o,
    output logic        cep_o,
    output logic        cen_o,
    output logic [13:0] ram_a_o,
    output logic [7:0]  ram_d_o,
    output logic        ram_we_o,
    input  logic [7:0]  ram_q_i,
    output logic [3:0]  stall_o
);

    typedef enum logic [2:0] {StVideo, StIdle, StCpuRd, StCpuWr, StDone} state_e;

    state_e      state_q, state_d;
    logic        phase_q, phase_d;
    logic        cep_q, cep_d;
    logic        cen_q, cen_d;
    logic [3:0]  stall_q, stall_d;
    // Set once a CPU rising edge got through; the next one then clears the stall count,
    // so the count of the access just finished stays readable for one CPU cycle.
    logic        freed_q, freed_d;
    logic [7:0]  cpu_di_q, cpu_di_d;

    logic in_window;
    logic contended;
    logic hold;
    logic wr_req;
    logic rd_req;

    assign in_window = (cpu_a_i[15:14] == CONT_PAGE);
    assign contended = in_window | (IO_CONTEND & ~cpu_iorq_n_i & ~cpu_a_i[0]);
    assign hold      = cn_i & contended;
    assign wr_req    = in_window & ~cpu_mreq_n_i & ~cpu_wr_n_i;
    assign rd_req    = in_window & ~cpu_mreq_n_i & ~cpu_rd_n_i;

    assign vd_o     = ram_q_i;
    assign ram_d_o  = cpu_do_i;
    assign cpu_di_o = cpu_di_q;
    assign cep_o    = cep_q;
    assign cen_o    = cen_q;
    assign stall_o  = stall_q;

    // CPU clock phase, enables and stall counter; phase freezes while the rising edge is held.
    always_comb begin
        phase_d = phase_q;
        cep_d   = 1'b0;
        cen_d   = 1'b0;
        stall_d = stall_q;
        freed_d = freed_q;
        if (ce_i) begin
            if (phase_q) begin
                cen_d   = 1'b1;
                phase_d = 1'b0;
            end else if (hold) begin
                if (stall_q != 4'hF) begin
                    stall_d = stall_q + 4'd1;
                end
                freed_d = 1'b0;
            end else begin
                cep_d   = 1'b1;
                phase_d = 1'b1;
                if (freed_q) begin
                    stall_d = 4'd0;
                end
                freed_d = 1'b1;
            end
        end
    end

    // RAM ownership FSM: next state, address mux, write strobe and read latch.
    always_comb begin
        state_d  = state_q;
        cpu_di_d = cpu_di_q;
        ram_we_o = 1'b0;
        ram_a_o  = {1'b0, va_i};
        case (state_q)
            StVideo: begin
                if (ce_i && !cn_i) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (ce_i) begin
                    if (wr_req) begin
                        state_d = StCpuWr;
                    end else if (rd_req) begin
                        state_d = StCpuRd;
                    end else if (cn_i) begin
                        state_d = StVideo;
                    end
                end
            end
            StCpuRd: begin
                ram_a_o = cpu_a_i[13:0];
                if (ce_i) begin
                    cpu_di_d = ram_q_i;
                    state_d  = StDone;
                end
            end
            StCpuWr: begin
                ram_a_o  = cpu_a_i[13:0];
                // Strobe is combinational on state so reset removes it immediately.
                ram_we_o = ce_i;
                if (ce_i) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                ram_a_o = 14'd0;
                // Wait for MREQ to end so one MREQ can never produce a second write.
                if (ce_i && cpu_mreq_n_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StVideo;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StVideo;
            phase_q  <= 1'b0;
            cep_q    <= 1'b0;
            cen_q    <= 1'b0;
            stall_q  <= 4'd0;
            freed_q  <= 1'b1;
            cpu_di_q <= 8'hFF;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cep_q    <= cep_d;
            cen_q    <= cen_d;
            stall_q  <= stall_d;
            freed_q  <= freed_d;
            cpu_di_q <= cpu_di_d;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: enable/contention vectors through a scoreboard, then CPU access sequences.
module tb_vram_arbiter;

    typedef struct packed {
        logic        cn;
        logic [15:0] a;
        logic        iorq_n;
        logic        cep;
        logic        cen;
        logic [3:0]  stall;
    } vec_t;

    typedef struct packed {
        logic       cep;
        logic       cen;
        logic [3:0] stall;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        cn;
    logic [12:0] va;
    logic        mreq_n, iorq_n, rd_n, wr_n;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_do;
    logic [7:0]  ram_q;

    logic [7:0]  vd, cpu_di, ram_d;
    logic        cep, cen, ram_we;
    logic [13:0] ram_a;
    logic [3:0]  stall;

    logic [7:0]  vd2, cpu_di2, ram_d2;
    logic        cep2, cen2, ram_we2;
    logic [13:0] ram_a2;
    logic [3:0]  stall2;

    int n_tests = 0;
    int n_fail  = 0;
    int we_cnt  = 0;
    int cep_cnt = 0;
    int cep2_cnt = 0;

    vec_t vecs[$];
    exp_t sbq[$];

    vram_arbiter u_dut (
        .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .cn_i(cn), .va_i(va), .vd_o(vd),
        .cpu_mreq_n_i(mreq_n), .cpu_iorq_n_i(iorq_n), .cpu_rd_n_i(rd_n), .cpu_wr_n_i(wr_n),
        .cpu_a_i(cpu_a), .cpu_do_i(cpu_do), .cpu_di_o(cpu_di), .cep_o(cep), .cen_o(cen),
        .ram_a_o(ram_a), .ram_d_o(ram_d), .ram_we_o(ram_we), .ram_q_i(ram_q), .stall_o(stall)
    );

    vram_arbiter #(.CONT_PAGE(2'b01), .IO_CONTEND(1'b0)) u_dut_noio (
        .clk_i(clk), .rst_ni(rst_n), .ce_i(ce), .cn_i(cn), .va_i(va), .vd_o(vd2),
        .cpu_mreq_n_i(mreq_n), .cpu_iorq_n_i(iorq_n), .cpu_rd_n_i(rd_n), .cpu_wr_n_i(wr_n),
        .cpu_a_i(cpu_a), .cpu_do_i(cpu_do), .cpu_di_o(cpu_di2), .cep_o(cep2), .cen_o(cen2),
        .ram_a_o(ram_a2), .ram_d_o(ram_d2), .ram_we_o(ram_we2), .ram_q_i(ram_q),
        .stall_o(stall2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) we_cnt <= we_cnt + 1;
        if (cep) cep_cnt <= cep_cnt + 1;
        if (cep2) cep2_cnt <= cep2_cnt + 1;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic c, input logic [15:0] a, input logic io_n,
                           input logic e_cep, input logic e_cen, input logic [3:0] e_stall);
        vec_t v;
        v.cn = c; v.a = a; v.iorq_n = io_n;
        v.cep = e_cep; v.cen = e_cen; v.stall = e_stall;
        vecs.push_back(v);
    endtask

    // One ce-qualified clock followed by one idle clock.
    task automatic ce_step();
        ce = 1'b1;
        @(posedge clk); #1;
        ce = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int we0, cep0, cep20;
        exp_t e;

        rst_n = 1'b0; ce = 1'b0; cn = 1'b0; va = 13'd0;
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        cpu_a = 16'h8000; cpu_do = 8'h00; ram_q = 8'h00;

        // Free run, no contention: cep/cen alternate, stall stays 0.
        for (int k = 0; k < 8; k++) add_vec(1'b0, 16'h8000, 1'b1, k % 2 == 0, k % 2 == 1, 4'd0);
        // Contended hold: no cep, phase frozen, stall counts; released edge comes on next ce.
        add_vec(1'b1, 16'h4000, 1'b1, 1'b0, 1'b0, 4'd1);
        add_vec(1'b1, 16'h4000, 1'b1, 1'b0, 1'b0, 4'd2);
        add_vec(1'b1, 16'h4000, 1'b1, 1'b0, 1'b0, 4'd3);
        add_vec(1'b0, 16'h4000, 1'b1, 1'b1, 1'b0, 4'd3);
        add_vec(1'b0, 16'h4000, 1'b1, 1'b0, 1'b1, 4'd3);
        add_vec(1'b0, 16'h4000, 1'b1, 1'b1, 1'b0, 4'd0);
        add_vec(1'b0, 16'h4000, 1'b1, 1'b0, 1'b1, 4'd0);
        // Uncontended page with cn=1.
        add_vec(1'b1, 16'h8000, 1'b1, 1'b1, 1'b0, 4'd0);
        add_vec(1'b1, 16'h8000, 1'b1, 1'b0, 1'b1, 4'd0);
        // I/O contention on even port only.
        add_vec(1'b1, 16'h00FE, 1'b0, 1'b0, 1'b0, 4'd1);
        add_vec(1'b1, 16'h00FE, 1'b0, 1'b0, 1'b0, 4'd2);
        add_vec(1'b1, 16'h00FF, 1'b0, 1'b1, 1'b0, 4'd2);
        add_vec(1'b1, 16'h00FF, 1'b0, 1'b0, 1'b1, 4'd2);
        add_vec(1'b1, 16'h00FF, 1'b0, 1'b1, 1'b0, 4'd0);
        add_vec(1'b1, 16'h00FF, 1'b0, 1'b0, 1'b1, 4'd0);
        // Saturation at 15, then release.
        for (int k = 0; k < 17; k++)
            add_vec(1'b1, 16'h4000, 1'b1, 1'b0, 1'b0, (k < 15) ? 4'(k + 1) : 4'd15);
        add_vec(1'b0, 16'h4000, 1'b1, 1'b1, 1'b0, 4'd15);
        add_vec(1'b0, 16'h4000, 1'b1, 1'b0, 1'b1, 4'd15);
        add_vec(1'b0, 16'h4000, 1'b1, 1'b1, 1'b0, 4'd0);

        // Reset state.
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst cep", 16'(cep), 16'd0);
        chk("rst cen", 16'(cen), 16'd0);
        chk("rst ram_we", 16'(ram_we), 16'd0);
        chk("rst cpu_di", 16'(cpu_di), 16'h00FF);
        chk("rst stall", 16'(stall), 16'd0);
        chk("rst ram_a", 16'(ram_a), 16'd0);
        rst_n = 1'b1;
        va = 13'h1ABC;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            cn = vecs[i].cn; cpu_a = vecs[i].a; iorq_n = vecs[i].iorq_n;
            e.cep = vecs[i].cep; e.cen = vecs[i].cen; e.stall = vecs[i].stall;
            sbq.push_back(e);
            ce = 1'b1;
            @(posedge clk); #1;
            if (sbq.size() == 0) begin
                chk($sformatf("vec%0d scoreboard empty", i), 16'd1, 16'd0);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("vec%0d cep", i), 16'(cep), 16'(e.cep));
                chk($sformatf("vec%0d cen", i), 16'(cen), 16'(e.cen));
                chk($sformatf("vec%0d stall", i), 16'(stall), 16'(e.stall));
            end
            ce = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("vec%0d width", i), 16'({cep, cen}), 16'd0);
        end
        chk("ram_a follows va", 16'(ram_a), 16'h1ABC);

        // I/O contention disabled on the second instance.
        cn = 1'b1; cpu_a = 16'h00FE; iorq_n = 1'b0;
        cep0 = cep_cnt; cep20 = cep2_cnt;
        for (int k = 0; k < 4; k++) ce_step();
        chk("io held cep count", 16'(cep_cnt - cep0), 16'd0);
        chk("noio cep count", 16'(cep2_cnt - cep20), 16'd2);
        cn = 1'b0; cpu_a = 16'h8000; iorq_n = 1'b1;
        ce_step();

        // CPU write: one strobe per MREQ.
        cpu_a = 16'h5800; cpu_do = 8'hA5; mreq_n = 1'b0; wr_n = 1'b0;
        we0 = we_cnt;
        #1 chk("wr idle no strobe", 16'(ram_we), 16'd0);
        ce_step();
        ce = 1'b1; #1;
        chk("wr strobe", 16'(ram_we), 16'd1);
        chk("wr ram_a", 16'(ram_a), 16'h1800);
        chk("wr ram_d", 16'(ram_d), 16'h00A5);
        @(posedge clk); #1;
        ce = 1'b0; #1;
        chk("wr strobe off", 16'(ram_we), 16'd0);
        @(posedge clk); #1;
        ce_step();
        ce_step();
        chk("wr strobe count", 16'(we_cnt - we0), 16'd1);
        mreq_n = 1'b1; wr_n = 1'b1;
        ce_step();

        // CPU read.
        cpu_a = 16'h4000; mreq_n = 1'b0; rd_n = 1'b0; ram_q = 8'h3C;
        ce_step();
        chk("rd before latch", 16'(cpu_di), 16'h00FF);
        ce_step();
        chk("rd cpu_di", 16'(cpu_di), 16'h003C);
        chk("vd passthrough", 16'(vd), 16'h003C);
        mreq_n = 1'b1; rd_n = 1'b1;
        ce_step();

        // Reset in the middle of a write.
        mreq_n = 1'b0; wr_n = 1'b0; cpu_a = 16'h4000;
        ce_step();
        ce = 1'b1; #1;
        chk("pre-reset strobe", 16'(ram_we), 16'd1);
        rst_n = 1'b0; #1;
        chk("reset ram_we", 16'(ram_we), 16'd0);
        chk("reset cpu_di", 16'(cpu_di), 16'h00FF);
        chk("reset stall", 16'(stall), 16'd0);
        chk("reset video ram_a", 16'(ram_a), 16'h1ABC);
        ce = 1'b0; mreq_n = 1'b1; wr_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
